// File: rtl/disp_pkg.sv
// Shared constants, owner/state encodings and the leading-zero mask helper
// for the shared 7-segment display arbiter.
package disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int NIB_W      = 4;
  localparam int DATA_W     = 24;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } state_t;

  // Digit k lights when any nibble at or above it is nonzero; digit 1 always lights.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DATA_W-1:0] data,
                                                    input logic             blank);
    logic [NUM_DIGITS-1:0] en;
    en = '1;
    if (blank) begin
      for (int k = 1; k < NUM_DIGITS; k++) begin
        en[k] = ((data >> (NIB_W * k)) != '0);
      end
    end
    return en;
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Hold-time prescaler: counts 0..TICK_DIV-1 and flags the last count as a
// one-cycle tick. A restart realigns the count so a new hold window is exact.
module disp_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_share_arbiter.sv
// Shares the six-digit display between the PS/2 (A) and UART/Modbus (B) paths:
// round-robin grant, minimum hold window, registered nibbles and digit enables.
module disp_share_arbiter
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int HOLD_MS  = 1000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic [DATA_W-1:0]     a_data,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  b_ack,
  output logic [DATA_W-1:0]     num_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [1:0]            owner,
  output logic                  busy
);

  localparam int HOLD_W = $clog2(HOLD_MS + 1);

  // Handshake: req is a level held until the matching one-cycle ack; req is
  // only sampled while that port's ack is low, so the ack cycle is ignored.
  state_t            state, state_n;
  logic              a_pend, a_pend_n, b_pend, b_pend_n;
  logic              last_a;
  logic              cap_a, cap_b, load;
  logic              a_s, b_s, tick, expire;
  logic [HOLD_W-1:0] hold_cnt;

  assign a_s    = a_req & ~a_ack;
  assign b_s    = b_req & ~b_ack;
  assign expire = (state != IDLE) && tick && (hold_cnt == HOLD_W'(1));
  assign busy   = (state != IDLE);
  assign owner  = (state == HOLD_A) ? OWNER_A :
                  (state == HOLD_B) ? OWNER_B : OWNER_NONE;

  disp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst),
    .restart (load),
    .tick    (tick)
  );

  always_comb begin
    state_n  = state;
    a_pend_n = a_pend;
    b_pend_n = b_pend;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_s && (!b_s || !last_a)) begin
          cap_a    = 1'b1;
          load     = 1'b1;
          state_n  = HOLD_A;
          b_pend_n = b_s;
          a_pend_n = 1'b0;
        end else if (b_s) begin
          cap_b    = 1'b1;
          load     = 1'b1;
          state_n  = HOLD_B;
          a_pend_n = a_s;
          b_pend_n = 1'b0;
        end
      end
      HOLD_A: begin
        if (expire) begin
          if (b_pend && b_s) begin
            cap_b    = 1'b1;
            load     = 1'b1;
            state_n  = HOLD_B;
            b_pend_n = 1'b0;
            a_pend_n = a_s;
          end else begin
            state_n  = IDLE;
            a_pend_n = 1'b0;
            b_pend_n = 1'b0;
          end
        end else begin
          // Owner refresh only extends the window when nobody else is waiting.
          if (a_s) begin
            cap_a = 1'b1;
            load  = !(b_pend || b_s);
          end
          if (b_s) b_pend_n = 1'b1;
        end
      end
      HOLD_B: begin
        if (expire) begin
          if (a_pend && a_s) begin
            cap_a    = 1'b1;
            load     = 1'b1;
            state_n  = HOLD_A;
            a_pend_n = 1'b0;
            b_pend_n = b_s;
          end else begin
            state_n  = IDLE;
            a_pend_n = 1'b0;
            b_pend_n = 1'b0;
          end
        end else begin
          if (b_s) begin
            cap_b = 1'b1;
            load  = !(a_pend || a_s);
          end
          if (a_s) a_pend_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      a_pend   <= 1'b0;
      b_pend   <= 1'b0;
      last_a   <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      num_out  <= '0;
      digit_en <= '0;
      hold_cnt <= '0;
    end else begin
      state  <= state_n;
      a_pend <= a_pend_n;
      b_pend <= b_pend_n;
      a_ack  <= cap_a;
      b_ack  <= cap_b;
      if (cap_a) begin
        last_a   <= 1'b1;
        num_out  <= a_data;
        digit_en <= lz_mask(a_data, LZ_BLANK);
      end else if (cap_b) begin
        last_a   <= 1'b0;
        num_out  <= b_data;
        digit_en <= lz_mask(b_data, LZ_BLANK);
      end
      if (load) begin
        hold_cnt <= HOLD_W'(HOLD_MS);
      end else if (tick && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

endmodule

// File: doc/disp_share_arbiter.md
Name: disp_share_arbiter

Overview:
- Shares the six-digit multiplexed 7-segment display between two requesters:
  - Port A: the PS/2 keycode path.
  - Port B: the UART/Modbus frame path.
- Each requester offers a 24-bit value (six BCD/hex nibbles) over a req/ack handshake.
- The block grants display ownership for a minimum hold time, arbitrates fairly, and drives the nibble inputs and per-digit enables of the display driver.

Parameters:
- TICK_DIV, 50000: clk cycles per hold tick (1 ms at 50 MHz); must be ≥2.
- HOLD_MS, 1000: ticks a granted value is guaranteed on display before the other port may take over; must be ≥1.
- LZ_BLANK, 1: 1 = suppress leading-zero digits via digit_en; 0 = all digits enabled once written.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- a_req  in  1  port A request (level)
- a_data  in  24  port A value; [3:0] = digit 1 (rightmost) … [23:20] = digit 6
- a_ack  out  1  one-cycle pulse: a_data captured
- b_req  in  1  port B request (level)
- b_data  in  24  port B value, same packing as a_data
- b_ack  out  1  one-cycle pulse: b_data captured
- num_out  out  24  six nibbles to the display driver, same packing
- digit_en  out  6  per-digit enable; bit k gates digit k+1
- owner  out  2  00 none, 01 A, 10 B
- busy  out  1  high while a hold window is running

Behaviour:
- Reset (rst low, asynchronous):
  - num_out = 0, digit_en = 0 (all dark), owner = 00, busy = 0, a_ack = b_ack = 0.
  - Pending flags, prescaler and hold counter are cleared; last-grant pointer = B, so A wins the first tie.
  - Reset mid-hold aborts everything; requesters still holding req are served after release, A first.
- Sampling: a port's req is sampled only at edges where its own ack is low. A req seen while its ack is high is ignored, so a port is served at most every 2 cycles.
- Capture: at capture edge E:
  - num_out is loaded; the ack, owner and digit_en updates are all visible after E.
  - The ack stays high exactly one cycle; the requester may change data or drop req while ack is high.
- IDLE (owner = 00):
  - One port requesting → grant that port.
  - Both requesting → grant the port not last granted (round-robin).
  - On grant: capture data, start hold; prescaler and hold counter reload, so the window is exactly HOLD_MS*TICK_DIV cycles.
- HOLD_A / HOLD_B (busy = 1):
  - Owner re-request: captured immediately and acked. The hold restarts only if the other port is not pending; otherwise the timer keeps running (no starvation).
  - Other-port request: sets its pending flag, no ack yet.
  - Expiry, other port pending with req still high: grant it at the expiry edge (capture + ack + new hold); owner switches with no gap cycle.
  - Expiry, pending flag set but req dropped: flag cleared, go IDLE.
  - Expiry, nothing pending: go IDLE, owner = 00, busy = 0. num_out and digit_en retain the last value (display never goes dark after first write).
  - Expiry coinciding with an owner re-request while the other is pending: the other port wins; the owner's request stays unserved until its next turn.
- digit_en (registered, updated with num_out):
  - LZ_BLANK = 1: bit 0 = 1; bit k (k = 1..5) = 1 iff some nibble at index ≥k is nonzero. All-zero data shows a single "0".
  - LZ_BLANK = 0: 6'b111111.
- Widths:
  - Prescaler is $clog2(TICK_DIV) bits, wraps at TICK_DIV-1 and emits a 1-cycle tick.
  - Hold counter is $clog2(HOLD_MS+1) bits, loads HOLD_MS and decrements on tick; expiry = counter 1 and tick.
  - No arithmetic on data; nibbles pass through unmodified.

Decomposition:
- Shared package disp_pkg:
  - Constants NUM_DIGITS = 6, NIB_W = 4, DATA_W = 24.
  - Owner encodings OWNER_NONE / OWNER_A / OWNER_B.
  - State encoding IDLE / HOLD_A / HOLD_B.
- One sub-module, disp_tick_gen: prescaler with synchronous restart input, active-low async reset, 1-cycle tick output.
- Arbiter FSM, pending flags, capture registers and leading-zero logic stay in disp_share_arbiter.

Test Plan (bench with TICK_DIV = 4, HOLD_MS = 3, so hold = 12 cycles):
- Reset release, a_req = 1, a_data = 24'h000123 → a_ack pulses 1 cycle; num_out = 000123, digit_en = 000111, owner = 01, busy = 1; IDLE 12 cycles later, owner = 00, num_out retained.
- a_req and b_req rise on the same edge → A granted first; B pending, acked exactly 12 cycles after a_ack, owner switches 01 → 10 with no IDLE cycle.
- During A hold, A re-requests 24'h000456 at cycle 5 with B pending → immediate a_ack and num_out = 000456; B still granted at cycle 12, the timer was not restarted.
- During A hold, A re-requests at cycle 10 with nothing pending → hold restarts; expiry at cycle 22.
- b_data = 24'h000000, LZ_BLANK = 1 → digit_en = 000001; b_data = 24'h900000 → digit_en = 111111.
- rst pulsed low at cycle 6 of a hold with B pending → all outputs zero immediately; after release with both reqs high, A is granted first.
